// File: rtl/lbist_pkg.sv
// lbist_pkg: shared types and helpers for the logic-BIST sequencer.
//   lbist_state_e         - sequencer state encoding
//   LbistMisrPolyDefault  - default MISR feedback polynomial (bit i set = tap i)
//   lbist_misr_next()     - one MISR step for any width up to MaxSigW
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StWarmup,
    StRun,
    StCmp,
    StDone
  } lbist_state_e;

  localparam int unsigned MaxSigW = 32;
  localparam logic [MaxSigW-1:0] LbistMisrPolyDefault = 32'h04C11DB7;

  // Operands are zero-extended to MaxSigW; the result is masked to `width` bits so the
  // caller can simply truncate.
  function automatic logic [MaxSigW-1:0] lbist_misr_next(input logic [MaxSigW-1:0] sig,
                                                         input logic [MaxSigW-1:0] resp,
                                                         input logic [MaxSigW-1:0] poly,
                                                         input int unsigned width);
    logic [MaxSigW-1:0] mask;
    logic               msb;
    mask = {MaxSigW{1'b1}} >> (MaxSigW - width);
    msb  = |(sig & ({{(MaxSigW-1){1'b0}}, 1'b1} << (width - 1)));
    return ({sig[MaxSigW-2:0], 1'b0} ^ (msb ? poly : '0) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// lbist_misr: multiple-input signature register compacting core responses.
//   clk   - clock
//   rst   - synchronous active-high reset, clears the signature
//   clr   - synchronous clear (takes priority over en)
//   en    - compact resp into the signature this cycle
//   resp  - folded core response, SIG_W bits
//   sig   - current signature, SIG_W bits
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int unsigned      SIG_W     = 32,
  parameter logic [SIG_W-1:0] MISR_POLY = LbistMisrPolyDefault[SIG_W-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] resp,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = SIG_W'(lbist_misr_next(MaxSigW'(sig_q), MaxSigW'(resp), MaxSigW'(MISR_POLY),
                                     SIG_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic-BIST sequencer. Seeds and steps the pattern LFSR, holds the core in
// reset while seeding, compacts responses in lbist_misr and compares against GOLDEN_SIG.
// Optional feature macro: LBIST_WARMUP_EN compiles in the WARMUP state (INIT_CYCLES long)
// between SEED and RUN; without it SEED goes straight to RUN and INIT_CYCLES is ignored.
//   clk        - clock
//   rst        - synchronous active-high reset, priority over everything
//   test_mode  - level request: rising edge starts a run, low level aborts it
//   resp       - folded core outputs, compacted every RUN cycle
//   lfsr_en    - LFSR step enable (WARMUP, RUN)
//   lfsr_ld    - LFSR seed load (SEED)
//   core_rst   - core-under-test reset (SEED)
//   busy       - SEED, WARMUP, RUN or CMP
//   done       - result valid (DONE)
//   go_nogo    - 1 = signature matched, valid while done
//   signature  - current MISR contents
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned      SIG_W       = 32,
  parameter logic [SIG_W-1:0] MISR_POLY   = LbistMisrPolyDefault[SIG_W-1:0],
  parameter int unsigned      N_PATTERNS  = 1024,
  parameter int unsigned      INIT_CYCLES = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_mode,
  input  logic [SIG_W-1:0] resp,
  output logic             lfsr_en,
  output logic             lfsr_ld,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             go_nogo,
  output logic [SIG_W-1:0] signature
);

`ifdef LBIST_WARMUP_EN
  // The counter is shared with WARMUP, so it must also cover INIT_CYCLES.
  localparam int unsigned CntMax = (N_PATTERNS > INIT_CYCLES) ? N_PATTERNS : INIT_CYCLES;
`else
  localparam int unsigned CntMax = N_PATTERNS;
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RunLast = CntW'(N_PATTERNS - 1);
`ifdef LBIST_WARMUP_EN
  localparam logic [CntW-1:0] WarmLast = CntW'(INIT_CYCLES - 1);
`endif

  lbist_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tm_q, tm_prev_q;
  logic            go_nogo_q, go_nogo_d;
  logic            in_run;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_nogo_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Edge seen on the registered request, so a held-high level never retriggers.
        if (tm_q && !tm_prev_q) state_d = StSeed;
      end
      StSeed: begin
        cnt_d = '0;
`ifdef LBIST_WARMUP_EN
        state_d = StWarmup;
`else
        state_d = StRun;
`endif
      end
`ifdef LBIST_WARMUP_EN
      StWarmup: begin
        if (cnt_q == WarmLast) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StRun: begin
        if (cnt_q == RunLast) begin
          cnt_d   = '0;
          state_d = StCmp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCmp: begin
        go_nogo_d = (signature == GOLDEN_SIG);
        state_d   = StDone;
      end
      StDone: begin
        go_nogo_d = go_nogo_q;
        if (!test_mode) begin
          go_nogo_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort: any busy state drops to IDLE; MISR keeps its partial value.
    if (!test_mode && busy) begin
      state_d   = StIdle;
      cnt_d     = '0;
      go_nogo_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tm_q      <= 1'b0;
      tm_prev_q <= 1'b0;
      go_nogo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tm_q      <= test_mode;
      tm_prev_q <= tm_q;
      go_nogo_q <= go_nogo_d;
    end
  end

  always_comb begin
    lfsr_ld  = (state_q == StSeed);
    core_rst = (state_q == StSeed);
    lfsr_en  = (state_q == StWarmup) || (state_q == StRun);
    busy     = (state_q == StSeed) || (state_q == StWarmup) || (state_q == StRun) ||
               (state_q == StCmp);
    done     = (state_q == StDone);
    in_run   = (state_q == StRun);
  end

  assign go_nogo = go_nogo_q;

  lbist_misr #(
    .SIG_W     (SIG_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (lfsr_ld),
    .en   (in_run),
    .resp (resp),
    .sig  (signature)
  );

endmodule

// File: tb/tb_lbist_ctrl.sv
// tb_lbist_ctrl: directed bench for lbist_ctrl with SIG_W=8, MISR_POLY=8'h1D,
// N_PATTERNS=4. Three instances share stimulus and differ only in GOLDEN_SIG
// (8'h00, 8'h0F, 8'h0E). Define LBIST_WARMUP_EN to exercise WARMUP with INIT_CYCLES=3.
module tb_lbist_ctrl;

`ifdef LBIST_WARMUP_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic       clk;
  logic       rst;
  logic       test_mode;
  logic [7:0] resp;

  logic       lfsr_en_w  [3];
  logic       lfsr_ld_w  [3];
  logic       core_rst_w [3];
  logic       busy_w     [3];
  logic       done_w     [3];
  logic       go_nogo_w  [3];
  logic [7:0] sig_w      [3];

  int checks = 0;
  int errors = 0;

  lbist_ctrl #(
    .SIG_W(8), .MISR_POLY(8'h1D), .N_PATTERNS(4), .INIT_CYCLES(3), .GOLDEN_SIG(8'h00)
  ) u_g00 (
    .clk(clk), .rst(rst), .test_mode(test_mode), .resp(resp),
    .lfsr_en(lfsr_en_w[0]), .lfsr_ld(lfsr_ld_w[0]), .core_rst(core_rst_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .go_nogo(go_nogo_w[0]), .signature(sig_w[0])
  );

  lbist_ctrl #(
    .SIG_W(8), .MISR_POLY(8'h1D), .N_PATTERNS(4), .INIT_CYCLES(3), .GOLDEN_SIG(8'h0F)
  ) u_g0f (
    .clk(clk), .rst(rst), .test_mode(test_mode), .resp(resp),
    .lfsr_en(lfsr_en_w[1]), .lfsr_ld(lfsr_ld_w[1]), .core_rst(core_rst_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .go_nogo(go_nogo_w[1]), .signature(sig_w[1])
  );

  lbist_ctrl #(
    .SIG_W(8), .MISR_POLY(8'h1D), .N_PATTERNS(4), .INIT_CYCLES(3), .GOLDEN_SIG(8'h0E)
  ) u_g0e (
    .clk(clk), .rst(rst), .test_mode(test_mode), .resp(resp),
    .lfsr_en(lfsr_en_w[2]), .lfsr_ld(lfsr_ld_w[2]), .core_rst(core_rst_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .go_nogo(go_nogo_w[2]), .signature(sig_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control outputs of u_g00 (identical across instances).
  task automatic ctl(input string tag, input logic ld, input logic en, input logic crst,
                     input logic bsy, input logic dn);
    chk({tag, ".lfsr_ld"}, 32'(lfsr_ld_w[0]), 32'(ld));
    chk({tag, ".lfsr_en"}, 32'(lfsr_en_w[0]), 32'(en));
    chk({tag, ".core_rst"}, 32'(core_rst_w[0]), 32'(crst));
    chk({tag, ".busy"}, 32'(busy_w[0]), 32'(bsy));
    chk({tag, ".done"}, 32'(done_w[0]), 32'(dn));
  endtask

  // Full run: test_mode rises just before edge t; done is expected at edge t+7+W.
  task automatic run_check(input string nm, input logic [7:0] r, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input logic g0, input logic g1, input logic g2, input int hold);
    logic [7:0] es [4];
    es = '{8'h00, e1, e2, e3};
    @(negedge clk);
    test_mode = 1'b1;
    resp      = (W > 0) ? 8'hFF : r;
    @(negedge clk);
    ctl({nm, ".t0"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ctl({nm, ".seed"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      ctl({nm, ".warm"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk({nm, ".warm.sig"}, 32'(sig_w[1]), 32'h00);
    end
    resp = r;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ctl({nm, ".run"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk({nm, ".run.sig"}, 32'(sig_w[1]), 32'(es[j]));
    end
    @(negedge clk);
    ctl({nm, ".cmp"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk({nm, ".cmp.sig"}, 32'(sig_w[1]), 32'(e4));
    @(negedge clk);
    ctl({nm, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({nm, ".go_g00"}, 32'(go_nogo_w[0]), 32'(g0));
    chk({nm, ".go_g0f"}, 32'(go_nogo_w[1]), 32'(g1));
    chk({nm, ".go_g0e"}, 32'(go_nogo_w[2]), 32'(g2));
    chk({nm, ".done.sig"}, 32'(sig_w[2]), 32'(e4));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      ctl({nm, ".hold"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk({nm, ".hold.go"}, 32'(go_nogo_w[1]), 32'(g1));
    end
    test_mode = 1'b0;
    @(negedge clk);
    ctl({nm, ".exit"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({nm, ".exit.go"}, 32'(go_nogo_w[1]), 32'h0);
    chk({nm, ".exit.sig"}, 32'(sig_w[1]), 32'(e4));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    test_mode = 1'b0;
    resp      = 8'h00;
    repeat (2) @(negedge clk);
    ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.go", 32'(go_nogo_w[0]), 32'h0);
    chk("reset.sig", 32'(sig_w[0]), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero response: only the 8'h00 golden instance passes.
    run_check("zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    // Constant 01: 01,03,07,0F. Held high afterwards must not retrigger.
    run_check("const", 8'h01, 8'h01, 8'h03, 8'h07, 8'h0F, 1'b0, 1'b1, 1'b0, 5);
    // Constant 80 exercises polynomial feedback: 80,9D,A7,D3.
    run_check("poly", 8'h80, 8'h80, 8'h9D, 8'hA7, 8'hD3, 1'b0, 1'b0, 1'b0, 0);

    // Abort during the 2nd RUN cycle; that cycle's sample still compacts (01 -> 03).
    @(negedge clk);
    test_mode = 1'b1;
    resp      = (W > 0) ? 8'hFF : 8'h01;
    @(negedge clk);
    @(negedge clk);
    ctl("abort.seed", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (W) @(negedge clk);
    resp = 8'h01;
    @(negedge clk);
    chk("abort.run1.sig", 32'(sig_w[1]), 32'h00);
    @(negedge clk);
    chk("abort.run2.sig", 32'(sig_w[1]), 32'h01);
    test_mode = 1'b0;
    @(negedge clk);
    ctl("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.go", 32'(go_nogo_w[1]), 32'h0);
    chk("abort.sig", 32'(sig_w[1]), 32'h03);
    @(negedge clk);
    ctl("abort.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Restart must clear the MISR in SEED.
    run_check("restart", 8'h01, 8'h01, 8'h03, 8'h07, 8'h0F, 1'b0, 1'b1, 1'b0, 0);

    // Reset mid-RUN.
    @(negedge clk);
    test_mode = 1'b1;
    resp      = (W > 0) ? 8'hFF : 8'h01;
    @(negedge clk);
    @(negedge clk);
    repeat (W) @(negedge clk);
    resp = 8'h01;
    repeat (3) @(negedge clk);
    ctl("rst.run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst.run.sig", 32'(sig_w[1]), 32'h03);
    rst       = 1'b1;
    test_mode = 1'b0;
    @(negedge clk);
    ctl("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.mid.sig", 32'(sig_w[1]), 32'h00);
    chk("rst.mid.go", 32'(go_nogo_w[1]), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    ctl("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
